// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared FSM encoding, counter sizing and defaults for mul_seq_controller.
// ACC_EN mirrors the MUL_ACCUMULATE_EN build macro.
package mul_seq_pkg;
    localparam int DEF_SIZE  = 16;
    localparam int DEF_GUARD = 4;
    localparam int DEF_WAIT  = 2;
`ifdef MUL_ACCUMULATE_EN
    localparam int ACC_EN = 1;
`else
    localparam int ACC_EN = 0;
`endif
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mul_seq_controller_ffd.sv
// FFD_POSEDGE_SYNCRONOUS_RESET: enabled register with synchronous active-high reset.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
    parameter int SIZE = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);
    always_ff @(posedge Clock)
        if (Reset) Q <= '0;
        else if (Enable) Q <= D;
endmodule

// File: rtl/mul_seq_controller_imul_gene.sv
// IMUL_GENE: combinational unsigned array multiplier, one shifted partial-product row per bit of B.
module IMUL_GENE #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0]   A,
    input  logic [SIZE-1:0]   B,
    output logic [2*SIZE-1:0] R
);
    logic [2*SIZE-1:0] w_row [SIZE+1];
    assign w_row[0] = '0;
    for (genvar i = 0; i < SIZE; i++) begin : g_row
        assign w_row[i+1] = w_row[i] + (B[i] ? ({{SIZE{1'b0}}, A} << i) : '0);
    end
    assign R = w_row[SIZE];
endmodule

// File: rtl/mul_seq_controller.sv
// mul_seq_controller: handshake wrapper that registers operands, waits for IMUL_GENE to settle
// and returns the product; MUL_ACCUMULATE_EN turns oResult into a wrapping accumulator.
module mul_seq_controller
    import mul_seq_pkg::*;
#(
    parameter  int SIZE        = DEF_SIZE,
    parameter  int WAIT_CYCLES = DEF_WAIT,
    parameter  int GUARD       = DEF_GUARD,
    localparam int RW          = 2*SIZE + GUARD*ACC_EN
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iValid,
    output logic            oReady,
    input  logic [SIZE-1:0] iA,
    input  logic [SIZE-1:0] iB,
`ifdef MUL_ACCUMULATE_EN
    input  logic            iAccClear,
    output logic            oOverflow,
`endif
    output logic            oValid,
    input  logic            iReady,
    output logic [RW-1:0]   oResult
);
    localparam int CW = cnt_w(WAIT_CYCLES + 1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_ready;
    logic                r_valid;
    logic [RW-1:0]       r_result;
    logic                w_take;
    logic [SIZE-1:0]     w_a;
    logic [SIZE-1:0]     w_b;
    logic [2*SIZE-1:0]   w_prod;
    logic [RW-1:0]       w_sum;

    assign w_take  = iValid & r_ready;
    assign oReady  = r_ready;
    assign oValid  = r_valid;
    assign oResult = r_result;

    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(SIZE)) u_reg_a (
        .Clock(Clock), .Reset(Reset), .Enable(w_take), .D(iA), .Q(w_a)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(SIZE)) u_reg_b (
        .Clock(Clock), .Reset(Reset), .Enable(w_take), .D(iB), .Q(w_b)
    );
    IMUL_GENE #(.SIZE(SIZE)) u_mul (.A(w_a), .B(w_b), .R(w_prod));

`ifdef MUL_ACCUMULATE_EN
    logic r_clr;
    logic r_ovf;
    logic w_carry;
    assign oOverflow = r_ovf;
    // oResult doubles as the accumulator; the extra top bit captures the carry-out.
    assign {w_carry, w_sum} = (r_clr ? (RW+1)'(0) : {1'b0, r_result}) + (RW+1)'(w_prod);
`else
    assign w_sum = w_prod;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
`ifdef MUL_ACCUMULATE_EN
            r_clr    <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state <= SETTLE;
                        r_ready <= 1'b0;
                        r_cnt   <= CW'(WAIT_CYCLES);
`ifdef MUL_ACCUMULATE_EN
                        r_clr   <= iAccClear;
                        if (iAccClear) r_ovf <= 1'b0;
`endif
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_sum;
`ifdef MUL_ACCUMULATE_EN
                        r_ovf    <= r_ovf | w_carry;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Re-arm oReady on the draining edge so IDLE can accept immediately.
                    if (iReady) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_controller.sv
// tb_mul_seq_controller: directed and randomized checks of mul_seq_controller against a
// product/accumulator model; build with MUL_ACCUMULATE_EN to cover accumulation.
module tb_mul_seq_controller;
    localparam int W   = 2;
    localparam bit ACC = (mul_seq_pkg::ACC_EN != 0);
    localparam int RW  = 32 + (ACC ? 4 : 0);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst = 1'b1;
    logic          vi = 1'b0, rdy_o, vo, ri = 1'b0;
    logic [15:0]   a = '0, b = '0;
    logic [RW-1:0] res;
    logic          vi0 = 1'b0, rdy0, vo0, ri0 = 1'b0;
    logic [3:0]    a0 = '0, b0 = '0;
    logic [7:0]    res0;
`ifdef MUL_ACCUMULATE_EN
    logic clr = 1'b0, ovf, clr0 = 1'b0, ovf0;
`endif

    mul_seq_controller u_dut (
        .Clock(clk), .Reset(rst), .iValid(vi), .oReady(rdy_o), .iA(a), .iB(b),
`ifdef MUL_ACCUMULATE_EN
        .iAccClear(clr), .oOverflow(ovf),
`endif
        .oValid(vo), .iReady(ri), .oResult(res)
    );

    mul_seq_controller #(.SIZE(4), .WAIT_CYCLES(0), .GUARD(0)) u_dut0 (
        .Clock(clk), .Reset(rst), .iValid(vi0), .oReady(rdy0), .iA(a0), .iB(b0),
`ifdef MUL_ACCUMULATE_EN
        .iAccClear(clr0), .oOverflow(ovf0),
`endif
        .oValid(vo0), .iReady(ri0), .oResult(res0)
    );

    int n_checks = 0, n_errors = 0;
    logic [RW-1:0] m_acc = '0;
    bit            m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] ta, input logic [15:0] tb, input bit tclr,
                        input int hold, input bit junk);
        int n, t0;
        logic [RW-1:0] exp, held;
        logic [RW:0]   s;
        n = 0;
        while (rdy_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("ready_wait", 64'(n < 20), 64'd1);
        vi = 1'b1; a = ta; b = tb;
`ifdef MUL_ACCUMULATE_EN
        clr = tclr;
`endif
        @(negedge clk);
        t0 = cyc; vi = 1'b0;
        s = (tclr ? (RW+1)'(0) : {1'b0, m_acc}) + (RW+1)'(32'(ta) * 32'(tb));
        m_ovf = (ACC && !tclr && m_ovf) || (ACC && s[RW]);
        m_acc = s[RW-1:0];
        exp = m_acc;
        n = 0;
        while (vo !== 1'b1 && n < 20) begin
            check("settle_ready", 64'(rdy_o), 64'd0);
            @(negedge clk); n++;
        end
        check("latency", 64'(cyc - t0), 64'(W + 1));
        check("result", 64'(res), 64'(exp));
`ifdef MUL_ACCUMULATE_EN
        check("overflow", 64'(ovf), 64'(m_ovf));
`endif
        held = res;
        repeat (hold) begin
            if (junk) begin vi = 1'b1; a = 16'($urandom); b = 16'($urandom); end
            @(negedge clk);
            check("hold_result", 64'(res), 64'(held));
            check("hold_valid", 64'(vo), 64'd1);
            check("hold_ready", 64'(rdy_o), 64'd0);
        end
        ri = 1'b1;
        @(negedge clk);
        ri = 1'b0; vi = 1'b0;
        check("drained", 64'(vo), 64'd0);
        check("idle_ready", 64'(rdy_o), 64'd1);
    endtask

    task automatic x0(input logic [3:0] ta, input logic [3:0] tb, input bit tclr,
                      input logic [7:0] e, input bit eo);
        int n, t0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("ready0_wait", 64'(n < 20), 64'd1);
        vi0 = 1'b1; a0 = ta; b0 = tb;
`ifdef MUL_ACCUMULATE_EN
        clr0 = tclr;
`endif
        @(negedge clk);
        t0 = cyc; vi0 = 1'b0;
        n = 0;
        while (vo0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("latency0", 64'(cyc - t0), 64'd1);
        check("result0", 64'(res0), 64'(e));
`ifdef MUL_ACCUMULATE_EN
        check("overflow0", 64'(ovf0), 64'(eo));
`else
        if (tclr && eo) $display("note: accumulate-only expectation skipped");
`endif
        ri0 = 1'b1;
        @(negedge clk);
        ri0 = 1'b0;
        check("drained0", 64'(vo0), 64'd0);
    endtask

    initial begin
        int acc_at [$];
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 64'(vo), 64'd0);
        check("rst_result", 64'(res), 64'd0);
        check("rst_ready", 64'(rdy_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 64'(rdy_o), 64'd1);

        xfer(16'd3, 16'd5, 1'b1, 0, 1'b0);
        xfer(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        xfer(16'h0000, 16'h1234, 1'b1, 0, 1'b0);
        xfer(16'd100, 16'd200, 1'b1, 10, 1'b1);

        while (rdy_o !== 1'b1) @(negedge clk);
        vi = 1'b1; a = 16'd3; b = 16'd3;
        @(negedge clk);
        vi = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_acc = '0; m_ovf = 1'b0;
        check("abort_valid", 64'(vo), 64'd0);
        check("abort_result", 64'(res), 64'd0);
        check("abort_ready", 64'(rdy_o), 64'd0);
        @(negedge clk);
        check("abort_idle", 64'(rdy_o), 64'd1);
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_valid", 64'(vo), 64'd0);
        end
        xfer(16'd7, 16'd6, 1'b1, 0, 1'b0);

        for (int i = 0; i < 25; i++)
            xfer(16'($urandom), 16'($urandom), ACC ? 1'($urandom_range(0, 1)) : 1'b1,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        x0(4'd9, 4'd9, 1'b1, 8'd81, 1'b0);
        x0(4'd15, 4'd15, 1'b1, 8'd225, 1'b0);
        x0(4'd15, 4'd15, 1'b0, ACC ? 8'd194 : 8'd225, ACC);
        x0(4'd2, 4'd3, 1'b1, 8'd6, 1'b0);

        vi0 = 1'b1; a0 = 4'd9; b0 = 4'd9; ri0 = 1'b1;
`ifdef MUL_ACCUMULATE_EN
        clr0 = 1'b1;
`endif
        for (int i = 0; i < 15; i++) begin
            if (rdy0) acc_at.push_back(cyc);
            if (vo0) check("b2b_result", 64'(res0), 64'd81);
            @(negedge clk);
        end
        vi0 = 1'b0;
        check("b2b_count", 64'(acc_at.size() >= 4), 64'd1);
        for (int i = 1; i < acc_at.size(); i++)
            check("b2b_gap", 64'(acc_at[i] - acc_at[i-1]), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
